// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding, fault cause codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

    localparam int CPU_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        WAIT_RSP = 3'd1,
        HOLD     = 3'd2,
        EXEC     = 3'd3,
        HALT     = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUS_ERR  = 2'b10;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, holds the word for decode, sticky halt on fault.
// Latency: request accepted in cycle N, response in N+1, instr_valid in N+2 at the earliest.
// Backpressure: req_valid/addr held until imem_req_ready; instr held until instr_ready.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = CPU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] current_pc,
    input  logic [DATA_WIDTH-1:0] next_pc,
    input  logic                  pc_load,
    output logic                  halted,
    output logic [1:0]            fault_cause,
    output logic [31:0]           retire_count
);

    fetch_state_t state;

    // imem_req_valid is its own register so it stays low through reset and
    // rises on the first clock after release, without a path from rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            current_pc     <= RESET_VECTOR;
            instr          <= '0;
            fault_cause    <= FC_NONE;
            retire_count   <= 32'd0;
            imem_req_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req_valid && imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= WAIT_RSP;
                    end else begin
                        imem_req_valid <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            fault_cause <= FC_BUS_ERR;
                            state       <= HALT;
                        end else begin
                            instr <= imem_rsp_data;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        retire_count <= retire_count + 32'd1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (pc_load) begin
                        if (is_word_aligned(next_pc[1:0])) begin
                            current_pc     <= next_pc;
                            imem_req_valid <= 1'b1;
                            state          <= FETCH;
                        end else begin
                            fault_cause <= FC_MISALIGN;
                            state       <= HALT;
                        end
                    end
                end
                HALT: begin
                    imem_req_valid <= 1'b0;
                end
                default: begin
                    imem_req_valid <= 1'b0;
                    state          <= HALT;
                end
            endcase
        end
    end

    assign imem_addr   = current_pc;
    assign instr_valid = (state == HOLD);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a 1-cycle behavioural instruction memory.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        pc_load;
    logic        halted;
    logic [1:0]  fault_cause;
    logic [31:0] retire_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    // memory model controls
    logic        mem_hold = 1'b0;
    logic        err_mode = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .current_pc     (current_pc),
        .next_pc        (next_pc),
        .pc_load        (pc_load),
        .halted         (halted),
        .fault_cause    (fault_cause),
        .retire_count   (retire_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_1040: return 32'h00A0_0093;
            32'h0000_0200: return 32'h0010_8113;
            default:       return 32'h0000_006F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_instr_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check(name, {31'd0, instr_valid}, 32'd1);
    endtask

    // memory: drives late in the low phase, after all stimulus for the cycle is settled
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            if (pend && !mem_hold) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                imem_rsp_err   = err_mode;
                pend = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
            end
        end
    end

    // monitor: every handoff to decode is popped from the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handoff", instr, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("handoff_instr", instr, e.word);
                    check("handoff_pc", current_pc, e.pc);
                end
            end
        end
    end

    initial begin
        int  n;
        logic saw;
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        pc_load = 1'b0;
        next_pc = 32'd0;

        // reset state
        repeat (3) step();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", current_pc, 32'd0);
        check("rst_flags", {28'd0, halted, fault_cause, 1'b0}, 32'd0);
        check("rst_retire", retire_count, 32'd0);

        // first fetch: addr 0 in cycle 1, instr in cycle 3
        exp_q.push_back('{32'h0, 32'h0000_0013});
        rst_n = 1'b1;
        step();
        check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("c1_addr", imem_addr, 32'd0);
        step();
        check("c2_instr_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_instr_stable", instr, 32'h0000_0013);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("retire_1", retire_count, 32'd1);
        check("exec_no_req", {31'd0, imem_req_valid}, 32'd0);

        // redirect to 0x1040; pc_load during HOLD ignored
        exp_q.push_back('{32'h1040, 32'h00A0_0093});
        next_pc = 32'h1040;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        check("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("redir_addr", imem_addr, 32'h1040);
        wait_instr_valid("wait_1040");
        next_pc = 32'h2000;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        check("hold_pcload_pc", current_pc, 32'h1040);
        check("hold_pcload_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("retire_2", retire_count, 32'd2);

        // request backpressure for 5 cycles, then retire_count wrap
        exp_q.push_back('{32'h200, 32'h0010_8113});
        imem_req_ready = 1'b0;
        next_pc = 32'h200;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("bp_addr", imem_addr, 32'h200);
            step();
        end
        imem_req_ready = 1'b1;
        wait_instr_valid("wait_200");
        force dut.retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count;
        step();
        check("retire_preset", retire_count, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("retire_wrap", retire_count, 32'd0);

        // misaligned redirect halts, PC unchanged, no more requests
        next_pc = 32'h3005;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_cause", {30'd0, fault_cause}, 32'd1);
        check("mis_pc", current_pc, 32'h200);
        next_pc = 32'h100;
        pc_load = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_req_valid || instr_valid || !halted) saw = 1'b1;
        end
        pc_load = 1'b0;
        check("halt_absorbing", {31'd0, saw}, 32'd0);
        check("halt_pc", current_pc, 32'h200);

        // reset during WAIT_RSP, stale response afterwards is dropped
        rst_n = 1'b0;
        step();
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_cause", {30'd0, fault_cause}, 32'd0);
        check("rst2_pc", current_pc, 32'd0);
        mem_hold = 1'b1;
        rst_n = 1'b1;
        step();
        step();
        check("wait_rsp_idle", {30'd0, imem_req_valid, instr_valid}, 32'd0);
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mem_hold = 1'b0;
        step();
        check("stale_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_instr", instr, 32'd0);
        step();
        check("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("restart_addr", imem_addr, 32'd0);
        exp_q.push_back('{32'h0, 32'h0000_0013});
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        n = 0;
        while (retire_count != 32'd1 && n < 20) begin
            step();
            n++;
        end
        instr_ready = 1'b0;
        check("restart_retire", retire_count, 32'd1);

        // bus error response halts without presenting an instruction
        err_mode = 1'b1;
        next_pc = 32'h40;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        saw = 1'b0;
        n = 0;
        while (!halted && n < 20) begin
            if (instr_valid) saw = 1'b1;
            step();
            n++;
        end
        check("err_halted", {31'd0, halted}, 32'd1);
        check("err_cause", {30'd0, fault_cause}, 32'd2);
        check("err_no_instr", {31'd0, saw | instr_valid}, 32'd0);
        check("err_no_req", {31'd0, imem_req_valid}, 32'd0);
        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
